// File: rtl/comparator_serial_n_bit_if.sv
// ---------------------------------------------------------------------------
// comparator_serial_n_bit_if
//
// Purpose: bundles the start/busy/done handshake, the operand bus and the
// registered one-hot result of the serial magnitude comparator.
//
// Signals:
//   start        master -> slave  request a compare (honoured only when idle)
//   signed_mode  master -> slave  1 = two's-complement, 0 = unsigned
//   num_A        master -> slave  operand A, WIDTH bits
//   num_B        master -> slave  operand B, WIDTH bits
//   busy         slave -> master  compare in progress
//   done         slave -> master  one-cycle pulse when the result updates
//   greater      slave -> master  A > B
//   lesser       slave -> master  A < B
//   equal        slave -> master  A == B
// ---------------------------------------------------------------------------
interface comparator_serial_n_bit_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] num_A;
  logic [WIDTH-1:0] num_B;
  logic             busy;
  logic             done;
  logic             greater;
  logic             lesser;
  logic             equal;

  // Controller side: issues requests, observes status and result
  modport master (
    output start, signed_mode, num_A, num_B,
    input  busy, done, greater, lesser, equal
  );

  // Comparator side: consumes requests, produces status and result
  modport slave (
    input  start, signed_mode, num_A, num_B,
    output busy, done, greater, lesser, equal
  );

endinterface

// File: rtl/comparator_serial_n_bit.sv
// ---------------------------------------------------------------------------
// comparator_serial_n_bit
//
// Purpose: sequential magnitude comparator. Two WIDTH-bit operands are
// compared DIGIT bits per cycle, most-significant slice first, stopping on
// the first slice that differs. Signed compares are reduced to unsigned ones
// by flipping the sign bit of both operands when they are captured
// (offset-binary mapping). The one-hot result is registered and held until
// the next completed operation.
//
// Parameters:
//   WIDTH  operand width (>= 2)
//   DIGIT  bits examined per cycle (WIDTH must be a multiple of DIGIT)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any operation in flight
//   bus    comparator_serial_n_bit_if.slave (start, signed_mode, num_A,
//          num_B in; busy, done, greater, lesser, equal out)
// ---------------------------------------------------------------------------
module comparator_serial_n_bit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  comparator_serial_n_bit_if.slave    bus
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic               done_q,    done_d;
  logic               greater_q, greater_d;
  logic               lesser_q,  lesser_d;
  logic               equal_q,   equal_d;

  logic [DIGIT-1:0]   a_slice;
  logic [DIGIT-1:0]   b_slice;

  // The slice under test is always the top DIGIT bits; the operand
  // registers are shifted left after every equal slice.
  assign a_slice = a_q[WIDTH-1 -: DIGIT];
  assign b_slice = b_q[WIDTH-1 -: DIGIT];

  // State and datapath registers. Reset abandons any compare in flight and
  // clears the result so nothing is reported until a fresh operation ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      lesser_q  <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      greater_q <= greater_d;
      lesser_q  <= lesser_d;
      equal_q   <= equal_d;
    end
  end

  // Next-state and datapath logic. Results hold by default and are only
  // rewritten on the edge that also raises done; done defaults low so it is
  // a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    done_d    = 1'b0;
    greater_d = greater_q;
    lesser_d  = lesser_q;
    equal_d   = equal_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flipping the MSB of both operands maps two's-complement order
          // onto unsigned order, so the slice logic never needs a sign case.
          a_d     = bus.signed_mode ? (bus.num_A ^ SIGN_BIT) : bus.num_A;
          b_d     = bus.signed_mode ? (bus.num_B ^ SIGN_BIT) : bus.num_B;
          cnt_d   = '0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (a_slice != b_slice) begin
          greater_d = (a_slice > b_slice);
          lesser_d  = (a_slice < b_slice);
          equal_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == LAST_SLICE) begin
          greater_d = 1'b0;
          lesser_d  = 1'b0;
          equal_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy is the COMPARE state itself, so it falls on the same edge that
  // raises done and is forced low by reset without a separate flop.
  assign bus.busy    = (state_q == COMPARE);
  assign bus.done    = done_q;
  assign bus.greater = greater_q;
  assign bus.lesser  = lesser_q;
  assign bus.equal   = equal_q;

endmodule

// File: tb/tb_comparator_serial_n_bit.sv
// ---------------------------------------------------------------------------
// tb_comparator_serial_n_bit
//
// Purpose: directed table of hand-computed compares on the default (8,2)
// configuration, multi-cycle corner sequences (back-to-back issue,
// asynchronous reset mid-operation), and a sweep over (8,1), (8,8) and
// (16,4) against a full-width reference model.
// ---------------------------------------------------------------------------
module tb_comparator_serial_n_bit;

  logic clk = 1'b0;
  logic rst_n;

  // 10 ns clock
  always #5 clk = ~clk;

  comparator_serial_n_bit_if #(.WIDTH(8))  main_if();
  comparator_serial_n_bit_if #(.WIDTH(8))  sw1_if();
  comparator_serial_n_bit_if #(.WIDTH(8))  sw8_if();
  comparator_serial_n_bit_if #(.WIDTH(16)) sw16_if();

  comparator_serial_n_bit #(.WIDTH(8),  .DIGIT(2)) dut_main (.clk(clk), .rst_n(rst_n), .bus(main_if.slave));
  comparator_serial_n_bit #(.WIDTH(8),  .DIGIT(1)) dut_w8d1 (.clk(clk), .rst_n(rst_n), .bus(sw1_if.slave));
  comparator_serial_n_bit #(.WIDTH(8),  .DIGIT(8)) dut_w8d8 (.clk(clk), .rst_n(rst_n), .bus(sw8_if.slave));
  comparator_serial_n_bit #(.WIDTH(16), .DIGIT(4)) dut_w16d4(.clk(clk), .rst_n(rst_n), .bus(sw16_if.slave));

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] res;   // {greater, lesser, equal}
    int         lat;
  } vec_t;

  vec_t vecs[11];

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation and lets one edge accept it (edge E0)
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sm);
    main_if.num_A       = a;
    main_if.num_B       = b;
    main_if.signed_mode = sm;
    main_if.start       = 1'b1;
    tick();
    main_if.start       = 1'b0;
  endtask

  // Waits for done on the main DUT; lat = cycles from E0, busyCnt = samples with busy high
  task automatic waitDone(input int limit, output int lat, output int busyCnt);
    lat     = 0;
    busyCnt = 0;
    while (!main_if.done && lat < limit) begin
      if (main_if.busy) busyCnt++;
      tick();
      main_if.start = 1'b0;
      lat++;
    end
  endtask

  // Reference: full-width compare for the result, leading equal slices for latency
  function automatic void model(input int w, input int d, input logic [15:0] a, input logic [15:0] b,
                                input logic sm, output logic [2:0] res, output int lat);
    logic [15:0] mask;
    logic [15:0] dm;
    logic [15:0] ua;
    logic [15:0] ub;
    int          sa;
    int          sb;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    dm   = (16'h1 << d) - 16'h1;
    ua   = a & mask;
    ub   = b & mask;
    if (!sm) begin
      sa = int'(ua);
      sb = int'(ub);
    end else if (w == 16) begin
      sa = $signed(ua);
      sb = $signed(ub);
    end else begin
      sa = $signed(ua[7:0]);
      sb = $signed(ub[7:0]);
    end
    res = (sa > sb) ? 3'b100 : ((sa < sb) ? 3'b010 : 3'b001);
    lat = w / d;
    for (int k = 0; k < w / d; k++) begin
      if (((ua >> (w - d - k * d)) & dm) != ((ub >> (w - d - k * d)) & dm)) begin
        lat = k + 1;
        break;
      end
    end
  endfunction

  // Runs one operation on all three sweep DUTs in lockstep for a fixed window
  task automatic sweepOne(input logic [15:0] a, input logic [15:0] b, input logic sm, input int idx);
    logic [2:0] expRes[3];
    int         expLat[3];
    logic [2:0] gotRes[3];
    int         dn[3];
    int         lt[3];
    int         bc[3];
    logic [2:0] doneV;
    logic [2:0] busyV;
    model(8,  1, a, b, sm, expRes[0], expLat[0]);
    model(8,  8, a, b, sm, expRes[1], expLat[1]);
    model(16, 4, a, b, sm, expRes[2], expLat[2]);
    sw1_if.num_A  = a[7:0]; sw1_if.num_B  = b[7:0]; sw1_if.signed_mode  = sm; sw1_if.start  = 1'b1;
    sw8_if.num_A  = a[7:0]; sw8_if.num_B  = b[7:0]; sw8_if.signed_mode  = sm; sw8_if.start  = 1'b1;
    sw16_if.num_A = a;      sw16_if.num_B = b;      sw16_if.signed_mode = sm; sw16_if.start = 1'b1;
    tick();
    sw1_if.start = 1'b0; sw8_if.start = 1'b0; sw16_if.start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      dn[j] = 0; lt[j] = 0; bc[j] = 0; gotRes[j] = 3'b000;
    end
    for (int c = 0; c < 20; c++) begin
      busyV = {sw16_if.busy, sw8_if.busy, sw1_if.busy};
      for (int j = 0; j < 3; j++) if (busyV[j]) bc[j]++;
      tick();
      doneV = {sw16_if.done, sw8_if.done, sw1_if.done};
      for (int j = 0; j < 3; j++) begin
        if (doneV[j]) begin
          dn[j]++;
          if (dn[j] == 1) lt[j] = c + 1;
        end
      end
      if (doneV[0] && dn[0] == 1) gotRes[0] = {sw1_if.greater,  sw1_if.lesser,  sw1_if.equal};
      if (doneV[1] && dn[1] == 1) gotRes[1] = {sw8_if.greater,  sw8_if.lesser,  sw8_if.equal};
      if (doneV[2] && dn[2] == 1) gotRes[2] = {sw16_if.greater, sw16_if.lesser, sw16_if.equal};
    end
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("sweep%0d cfg%0d done count", idx, j), 32'(dn[j]), 32'd1);
      checkOutput($sformatf("sweep%0d cfg%0d latency", idx, j), 32'(lt[j]), 32'(expLat[j]));
      checkOutput($sformatf("sweep%0d cfg%0d busy cycles", idx, j), 32'(bc[j]), 32'(expLat[j]));
      checkOutput($sformatf("sweep%0d cfg%0d result", idx, j), 32'(gotRes[j]), 32'(expRes[j]));
    end
    checkOutput($sformatf("sweep%0d held results", idx),
                32'({sw16_if.greater, sw16_if.lesser, sw16_if.equal,
                     sw8_if.greater,  sw8_if.lesser,  sw8_if.equal,
                     sw1_if.greater,  sw1_if.lesser,  sw1_if.equal}),
                32'({expRes[2], expRes[1], expRes[0]}));
  endtask

  // Watchdog so a stuck run still ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Main stimulus: reset, directed table, corner sequences, parameter sweep
  initial begin
    int          lat;
    int          busyCnt;
    int          extraDone;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0]  = '{8'hA5, 8'h25, 1'b0, 3'b100, 1};
    vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 3'b001, 4};
    vecs[2]  = '{8'h80, 8'h7F, 1'b1, 3'b010, 1};
    vecs[3]  = '{8'h80, 8'h7F, 1'b0, 3'b100, 1};
    vecs[4]  = '{8'hFF, 8'hFE, 1'b1, 3'b100, 4};
    vecs[5]  = '{8'h12, 8'h13, 1'b0, 3'b010, 4};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 3'b001, 4};
    vecs[7]  = '{8'h7F, 8'h80, 1'b1, 3'b100, 1};
    vecs[8]  = '{8'h24, 8'h14, 1'b0, 3'b100, 2};
    vecs[9]  = '{8'h05, 8'h09, 1'b0, 3'b010, 3};
    vecs[10] = '{8'hFE, 8'hFF, 1'b1, 3'b010, 4};

    main_if.start = 1'b0; main_if.signed_mode = 1'b0; main_if.num_A = '0; main_if.num_B = '0;
    sw1_if.start  = 1'b0; sw1_if.signed_mode  = 1'b0; sw1_if.num_A  = '0; sw1_if.num_B  = '0;
    sw8_if.start  = 1'b0; sw8_if.signed_mode  = 1'b0; sw8_if.num_A  = '0; sw8_if.num_B  = '0;
    sw16_if.start = 1'b0; sw16_if.signed_mode = 1'b0; sw16_if.num_A = '0; sw16_if.num_B = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset state");
    checkOutput("reset main outputs",
                32'({main_if.busy, main_if.done, main_if.greater, main_if.lesser, main_if.equal}), 32'd0);
    checkOutput("reset sweep outputs",
                32'({sw1_if.busy, sw1_if.done, sw1_if.greater, sw1_if.lesser, sw1_if.equal,
                     sw8_if.busy, sw8_if.done, sw8_if.greater, sw8_if.lesser, sw8_if.equal,
                     sw16_if.busy, sw16_if.done, sw16_if.greater, sw16_if.lesser, sw16_if.equal}), 32'd0);

    // Directed table; operands are scrambled and start re-pulsed right after
    // acceptance, which must change neither the result nor the done count.
    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sm);
      main_if.num_A       = ~vecs[i].a;
      main_if.num_B       = ~vecs[i].b;
      main_if.signed_mode = ~vecs[i].sm;
      main_if.start       = 1'b1;
      waitDone(10, lat, busyCnt);
      checkOutput($sformatf("vec%0d result", i),
                  32'({main_if.greater, main_if.lesser, main_if.equal}), 32'(vecs[i].res));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'(vecs[i].lat));
      extraDone = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (main_if.done || main_if.busy) extraDone++;
      end
      checkOutput($sformatf("vec%0d no extra done/busy", i), 32'(extraDone), 32'd0);
      checkOutput($sformatf("vec%0d result held", i),
                  32'({main_if.greater, main_if.lesser, main_if.equal}), 32'(vecs[i].res));
    end

    // Back-to-back: a start presented in the done cycle is accepted
    $display("[TB] back-to-back issue");
    applyStimulus(8'h80, 8'h7F, 1'b0);
    waitDone(10, lat, busyCnt);
    checkOutput("b2b first result", 32'({main_if.greater, main_if.lesser, main_if.equal}), 32'(3'b100));
    checkOutput("b2b first latency", 32'(lat), 32'd1);
    applyStimulus(8'h05, 8'h09, 1'b0);
    checkOutput("b2b second accepted busy", 32'(main_if.busy), 32'd1);
    waitDone(10, lat, busyCnt);
    checkOutput("b2b second result", 32'({main_if.greater, main_if.lesser, main_if.equal}), 32'(3'b010));
    checkOutput("b2b second latency", 32'(lat), 32'd3);
    tick();
    checkOutput("b2b done width", 32'(main_if.done), 32'd0);

    // Asynchronous reset two edges into a full-length compare
    $display("[TB] reset mid-operation");
    applyStimulus(8'h3C, 8'h3C, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs",
                32'({main_if.busy, main_if.done, main_if.greater, main_if.lesser, main_if.equal}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extraDone = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (main_if.done || main_if.busy) extraDone++;
    end
    checkOutput("no done after reset release", 32'(extraDone), 32'd0);
    checkOutput("outputs clear after reset",
                32'({main_if.greater, main_if.lesser, main_if.equal}), 32'd0);
    applyStimulus(8'h01, 8'h00, 1'b0);
    waitDone(10, lat, busyCnt);
    checkOutput("post-reset result", 32'({main_if.greater, main_if.lesser, main_if.equal}), 32'(3'b100));
    checkOutput("post-reset latency", 32'(lat), 32'd4);

    // Parameter sweep against the reference model
    $display("[TB] parameter sweep");
    sweepOne(16'h8000, 16'h7FFF, 1'b1, 0);
    sweepOne(16'h0080, 16'h007F, 1'b1, 1);
    sweepOne(16'hABCD, 16'hABCD, 1'b0, 2);
    for (int i = 3; i < 30; i++) begin
      ra = 16'($urandom);
      case (i % 3)
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h1 << $urandom_range(0, 15));
      endcase
      sweepOne(ra, rb, 1'($urandom_range(0, 1)), i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
